inline_interleave: RTL and testbench

- Inverse of the in-line reorder stage. Accepts a line stored as low/even half followed by high/odd half: L0..L(m-1), H0..H(n-m-1), with m = ceil(n/2).
- Emits the line interleaved: L0 H0 L1 H1 ... It sits on the inverse-DWT path, after each 1-D synthesis step.
- Line length n is taken from in_eol per line (1..MaxLineSize).
- Lines are buffered in one or two banks, so one line can be written while the previous one is read.

---
 rtl/reorder_pkg.sv | 19 +
 rtl/line_bank_ram.sv | 29 ++
 rtl/inline_interleave.sv | 174 +++++++++++++++++
 tb/tb_inline_interleave.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_pkg.sv
// Shared definitions for the in-line reorder / interleave stages.
//   DefDataWidth, DefMaxLineSize : default sample width and line capacity
//   AddrWidth, LenWidth          : index and length widths for the defaults
//   Data_t                       : sample type at the default width
//   half_ceil(len)               : size of the low/even half, ceil(len/2)
package reorder_pkg;

    localparam int DefDataWidth   = 8;
    localparam int DefMaxLineSize = 8;
    localparam int AddrWidth      = $clog2(DefMaxLineSize);
    localparam int LenWidth       = $clog2(DefMaxLineSize + 1);

    typedef logic [DefDataWidth-1:0] Data_t;

    function automatic int unsigned half_ceil(input int unsigned len);
        return (len + 1) / 2;
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Line buffer storage: simple dual-port RAM, one synchronous write port and
// one asynchronous read port. The bank index occupies the upper address part.
//   clk            : clock
//   we/waddr/wdata : write port
//   raddr/rdata    : combinational read port
module line_bank_ram #(
    parameter int Width = 8,
    parameter int Depth = 16,
    parameter int AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inline_interleave.sv
// Inverse of the in-line reorder stage. A line arrives as its low/even half
// followed by its high/odd half and leaves interleaved L0 H0 L1 H1 ...
// Lines are buffered in one bank or two ping-pong banks.
//   clk, rst                     : clock, synchronous active-low reset
//   in_data/in_valid/in_ready    : input sample stream
//   in_sof/in_eol                : first sample of frame / last of line
//   out_data/out_valid/out_ready : output sample stream
//   out_sof/out_eol              : first sample of frame / last of line
module inline_interleave
    import reorder_pkg::*;
#(
    parameter int DataWidth   = 8,
    parameter int MaxLineSize = 8,
    parameter int DoubleBuff  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic                 in_eol,
    output logic [DataWidth-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic                 out_eol
);

    localparam int AW       = $clog2(MaxLineSize);
    localparam int LW       = $clog2(MaxLineSize + 1);
    localparam int RamDepth = (1 + DoubleBuff) * MaxLineSize;
    localparam int RamAW    = $clog2(RamDepth);

    logic [AW-1:0]        wa_q, wa_d;
    logic                 wb_q, wb_d;
    logic                 rb_q, rb_d;
    logic [AW-1:0]        k_q, k_d;
    logic [1:0]           full_q, full_d;
    logic [1:0]           sof_q, sof_d;
    logic [LW-1:0]        len_q [2];
    logic [LW-1:0]        len_d [2];
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;
    logic                 out_sof_q, out_sof_d;
    logic                 out_eol_q, out_eol_d;

    logic                 in_fire;
    logic                 out_load;
    logic                 last_k;
    logic [AW-1:0]        rd_off;
    logic                 ram_we;
    logic [RamAW-1:0]     ram_waddr;
    logic [RamAW-1:0]     ram_raddr;
    logic [DataWidth-1:0] ram_rdata;

    line_bank_ram #(
        .Width (DataWidth),
        .Depth (RamDepth)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (in_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        wa_d        = wa_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        k_d         = k_q;
        full_d      = full_q;
        sof_d       = sof_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;

        // in_ready_q is only high while bank wb is not full, so a write can
        // never land in a bank that is still waiting to be read.
        in_fire   = in_valid && in_ready_q;
        ram_we    = in_fire;
        ram_waddr = (wb_q ? RamAW'(MaxLineSize) : RamAW'(0)) + RamAW'(wa_q);

        if (in_fire) begin
            if (wa_q == '0) begin
                sof_d[wb_q] = in_sof;
            end
            // A line that reaches the bank capacity closes on its own; the
            // following sample begins a new line.
            if (in_eol || (wa_q == AW'(MaxLineSize - 1))) begin
                len_d[wb_q]  = LW'(wa_q) + LW'(1);
                full_d[wb_q] = 1'b1;
                wa_d         = '0;
                if (DoubleBuff != 0) begin
                    wb_d = ~wb_q;
                end
            end else begin
                wa_d = wa_q + AW'(1);
            end
        end

        // Even outputs walk the low half, odd outputs walk the high half
        // starting at ceil(len/2).
        rd_off = k_q[0] ? AW'(half_ceil(32'(len_q[rb_q])) + 32'(k_q >> 1))
                        : (k_q >> 1);
        ram_raddr = (rb_q ? RamAW'(MaxLineSize) : RamAW'(0)) + RamAW'(rd_off);

        out_load = (!out_valid_q || out_ready) && full_q[rb_q];
        last_k   = (LW'(k_q) + LW'(1)) == len_q[rb_q];

        if (out_load) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_rdata;
            out_sof_d   = sof_q[rb_q] && (k_q == '0);
            out_eol_d   = last_k;
            if (last_k) begin
                full_d[rb_q] = 1'b0;
                k_d          = '0;
                if (DoubleBuff != 0) begin
                    rb_d = ~rb_q;
                end
            end else begin
                k_d = k_q + AW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        in_ready_d = !full_d[wb_d];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wa_q        <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            k_q         <= '0;
            full_q      <= '0;
            sof_q       <= '0;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            wa_q        <= wa_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            k_q         <= k_d;
            full_q      <= full_d;
            sof_q       <= sof_d;
            len_q       <= len_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_inline_interleave.sv
// Scoreboard bench for inline_interleave: stimulus pushes expected samples,
// a negedge monitor pops and compares on every output transfer.
module tb_inline_interleave;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sof = 1'b0;
    logic       in_eol = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_sof;
    logic       out_eol;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   acc_cnt = 0;
    bit   rnd_en = 0;
    bit   feed_done = 0;

    inline_interleave dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic s, input logic e);
        exp_t x;
        x.d = d;
        x.s = s;
        x.e = e;
        sb.push_back(x);
    endtask

    // Interleave order of an 8-sample line as offsets into the input order.
    task automatic push_line8(input logic [7:0] base, input logic s);
        logic [7:0] ofs [8];
        ofs = '{8'd0, 8'd4, 8'd1, 8'd5, 8'd2, 8'd6, 8'd3, 8'd7};
        for (int i = 0; i < 8; i++) begin
            push(base + ofs[i], s && (i == 0), i == 7);
        end
    endtask

    // Called and returns at posedge+1.
    task automatic send(input logic [7:0] d, input logic s, input logic e);
        int t;
        bit done;
        t = 0;
        done = 0;
        in_data = d;
        in_sof = s;
        in_eol = e;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 300) begin
                n_vec++;
                n_err++;
                $display("FAIL send_timeout: got no in_ready for data %0h required within 300 cycles", d);
                done = 1;
            end
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eol = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (in_valid && in_ready) acc_cnt++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {22'd0, out_sof, out_eol, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("out_sample", {22'd0, out_sof, out_eol, out_data}, {22'd0, x.s, x.e, x.d});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int mark, cnt, gaps, t, hi;
        logic [7:0] orig [8];
        logic [7:0] stim [8];

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_flags", {out_sof, out_eol, out_data}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Length 8 with latency check
        out_ready = 1'b1;
        push(8'h00, 1, 0); push(8'h04, 0, 0); push(8'h01, 0, 0); push(8'h05, 0, 0);
        push(8'h02, 0, 0); push(8'h06, 0, 0); push(8'h03, 0, 0); push(8'h07, 0, 1);
        for (int i = 0; i < 8; i++) send(8'(i), i == 0, i == 7);
        check("lat_edge1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge2_valid", out_valid, 1);
        drain();

        // Length 5 and length 1
        push(8'h10, 0, 0); push(8'h13, 0, 0); push(8'h11, 0, 0); push(8'h14, 0, 0); push(8'h12, 0, 1);
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 0, i == 4);
        push(8'h20, 1, 1);
        send(8'h20, 1, 1);
        drain();

        // Backpressure: two banks fill, third line waits
        out_ready = 1'b0;
        push_line8(8'h40, 0);
        push_line8(8'h50, 0);
        push_line8(8'h60, 0);
        mark = acc_cnt;
        feed_done = 0;
        fork
            begin
                for (int l = 0; l < 3; l++)
                    for (int i = 0; i < 8; i++)
                        send(8'h40 + 8'(l * 16 + i), 0, i == 7);
                feed_done = 1;
            end
        join_none
        repeat (40) @(posedge clk);
        #1;
        check("bp_accepted", acc_cnt - mark, 16);
        check("bp_in_ready", in_ready, 0);
        check("bp_held", {out_valid, out_data}, {1'b1, 8'h40});
        out_ready = 1'b1;
        cnt = 0;
        gaps = 0;
        t = 0;
        while (cnt < 24 && t < 300) begin
            @(negedge clk);
            if (out_valid) cnt++;
            else if (cnt > 0) gaps++;
            t++;
        end
        check("bp_out_count", cnt, 24);
        check("bp_gaps", gaps, 0);
        t = 0;
        while (!feed_done && t < 300) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("bp_feed_done", feed_done, 1);
        drain();

        // Overflow: 10 samples with a single eol
        push_line8(8'h30, 0);
        push(8'h38, 0, 0);
        push(8'h39, 0, 1);
        for (int i = 0; i < 10; i++) send(8'h30 + 8'(i), 0, i == 9);
        drain();

        // Reset with a full bank pending and a partial line
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h70 + 8'(i), 0, i == 7);
        for (int i = 0; i < 4; i++) send(8'h78 + 8'(i), 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        rst = 1'b1;
        out_ready = 1'b1;
        hi = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) hi++;
        end
        check("post_rst_no_out", hi, 0);
        check("post_rst_ready2", in_ready, 1);
        push_line8(8'h80, 1);
        for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), i == 0, i == 7);
        drain();

        // Round trip through an in-line reorder model with random handshakes
        rnd_en = 1;
        for (int l = 0; l < 8; l++) begin
            for (int i = 0; i < 8; i++) orig[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 4; i++) begin
                stim[i]     = orig[2 * i];
                stim[i + 4] = orig[2 * i + 1];
            end
            for (int i = 0; i < 8; i++) push(orig[i], (l == 0) && (i == 0), i == 7);
            for (int i = 0; i < 8; i++) begin
                int n;
                n = $urandom_range(0, 2);
                repeat (n) begin
                    @(posedge clk);
                    #1;
                end
                send(stim[i], (l == 0) && (i == 0), i == 7);
            end
        end
        rnd_en = 0;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
